// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter and its picker.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents:
//   arb_state_e : arbiter FSM states (ARB_IDLE, ARB_BURST)
//   STATS_W     : width of each per-requester transfer counter
//   STATS_MAX   : saturation value of those counters
//   sat_inc()   : saturating increment used by the optional statistics
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int STATS_W = 16;
  localparam logic [STATS_W-1:0] STATS_MAX = '1;

  // Counts stick at all-ones rather than wrapping back to zero.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    if (v == STATS_MAX) begin
      return v;
    end
    return v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first requester set in the mask after the last grant, cyclically.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the pick is used.
//
// Ports:
//   mask_i  in  NUM_REQ : request bits to choose from
//   last_i  in  IDX_W   : index granted most recently
//   found_o out 1       : at least one mask bit is set
//   idx_o   out IDX_W   : chosen index (0 when nothing is found)
module fifo_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate towards the nearest one so that the
  // last hit written is the closest index after last_i. Offset NUM_REQ wraps
  // back onto last_i itself, so a lone requester can be re-granted.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
      if (mask_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among NUM_REQ valid/ready producers.
// Latency: 1 arbitration cycle per burst; accepted word reaches wr_en/data_in 1 cycle after the handshake.
// Backpressure: req_ready drops while the FIFO is full or about to be filled by the in-flight write; the burst is held, not forfeited.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (req_ready is one-hot or zero)
//   req_data              : requester i word at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   full/almostfull       : FIFO flags used for back-pressure
//   overflow              : FIFO overflow pulse, captured into sticky err
//   wr_en/data_in         : registered FIFO write port
//   owner/busy            : current grant index, burst in progress
//   grant_cnt             : per-requester saturating transfer counts (only with FIFO_ARB_STATS_EN)
//
// Build option: define FIFO_ARB_STATS_EN to add the grant_cnt statistics port.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  input  logic                          almostfull,
  input  logic                          overflow,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic                          err
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0]    grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic                  space_ok;
  logic                  xfer;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [FIFO_WIDTH-1:0] owner_dat;

  // A write still sitting in the output register will land on the last free
  // slot when almostfull is up, so that case counts as no space.
  assign space_ok  = !full && !(wr_en_q && almostfull);
  assign owner_dat = req_data[int'(owner_q)*FIFO_WIDTH +: FIFO_WIDTH];

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .mask_i  (req_valid),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Ready depends only on registered state and the FIFO flags, never on
  // req_valid, so producers may derive valid from ready without a loop.
  always_comb begin
    req_ready = '0;
    if (state_q == ARB_BURST && space_ok) begin
      req_ready[owner_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
    data_d  = data_q;
    err_d   = err_q | overflow;
    xfer    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BURST;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ARB_BURST: begin
        if (!req_valid[owner_q]) begin
          // Owner ran dry: release the grant.
          state_d = ARB_IDLE;
          last_d  = owner_q;
        end else if (space_ok) begin
          xfer    = 1'b1;
          wr_en_d = 1'b1;
          data_d  = owner_dat;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == CNT_LAST) begin
            state_d = ARB_IDLE;
            last_d  = owner_q;
          end
        end
        // Otherwise stalled on FIFO space: hold owner and count.
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign data_in = data_q;
  assign owner   = owner_q;
  assign busy    = (state_q == ARB_BURST);
  assign err     = err_q;

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0] gcnt_q [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer && owner_q == IDX_W'(i)) begin
          gcnt_q[i] <= sat_inc(gcnt_q[i]);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    assign grant_cnt[g*STATS_W +: STATS_W] = gcnt_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized producers plus a FIFO occupancy model checked against a rule-level reference.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int BM    = 4;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           full, almostfull, overflow;
  logic           wr_en;
  logic [W-1:0]   data_in;
  logic [1:0]     owner;
  logic           busy, err;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .BURST_MAX(BM)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .full       (full),
    .almostfull (almostfull),
    .overflow   (overflow),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .owner      (owner),
    .busy       (busy),
    .err        (err)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: arbitration rules, FIFO occupancy, producers.
  bit           m_busy;
  int           m_owner, m_last, m_words;
  bit           m_wr;
  logic [W-1:0] m_data;
  int           cnt, max_cnt;
  bit           wr_prev, rd_prev;
  bit           hold   [N];
  logic [W-1:0] word   [N];
  int           seq    [N];
  int           tx_cnt [N];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         rdy;
    logic         wr;
    logic [W-1:0] din;
    logic         bsy;
  } vec_t;
  vec_t tv [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_next(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_data = '0;
    full = 1'b0; almostfull = 1'b0; overflow = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_busy = 0; m_owner = 0; m_last = N - 1; m_words = 0; m_wr = 0; m_data = '0;
    cnt = 0; max_cnt = 0; wr_prev = 0; rd_prev = 0;
    for (int i = 0; i < N; i++) begin
      hold[i] = 0; word[i] = '0; seq[i] = 0; tx_cnt[i] = 0;
    end
  endtask

  // Randomized producers against a FIFO of DEPTH words drained at rd_pct percent.
  task automatic run_rand(input int ncyc, input int rd_pct, input int v_pct);
    bit           rd, space, acc;
    logic [N-1:0] er;
    for (int c = 0; c < ncyc; c++) begin
      cnt = cnt + int'(wr_prev) - int'(rd_prev);
      if (cnt > max_cnt) max_cnt = cnt;
      full       = (cnt >= DEPTH);
      almostfull = (cnt == DEPTH - 1);
      overflow   = 1'b0;
      rd = (cnt > 0) && ($urandom_range(99) < rd_pct);
      for (int i = 0; i < N; i++) begin
        if (!hold[i] && ($urandom_range(99) < v_pct)) begin
          hold[i] = 1;
          word[i] = 16'((i << 12) | (seq[i] & 'hFFF));
          seq[i]++;
        end
        req_valid[i] = hold[i];
        req_data[i*W +: W] = word[i];
      end
      #1;
      space = !full && !(m_wr && almostfull);
      er = '0;
      if (m_busy && space) er[m_owner] = 1'b1;
      chk("rnd_ready", req_ready, er);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_wr_en", wr_en, m_wr);
      chk("rnd_data_in", data_in, m_data);
      if (m_busy) chk("rnd_owner", owner, m_owner);
      chk("rnd_err", err, 0);
      // Advance the reference by the arbitration rules.
      acc = m_busy && space && hold[m_owner];
      m_wr = acc;
      if (acc) begin
        m_data = word[m_owner];
        tx_cnt[m_owner]++;
      end
      if (m_busy) begin
        if (!hold[m_owner]) begin
          m_busy = 0; m_last = m_owner;
        end else if (acc) begin
          m_words++;
          if (m_words == BM) begin
            m_busy = 0; m_last = m_owner;
          end
        end
      end else if (req_valid != '0) begin
        m_owner = rr_next(m_last, req_valid);
        m_busy = 1; m_words = 0;
      end
      // Producers react to what the DUT actually offered.
      for (int i = 0; i < N; i++) begin
        if (hold[i] && req_ready[i]) hold[i] = 0;
      end
      wr_prev = wr_en;
      rd_prev = rd;
      next();
    end
  endtask

  initial begin
    int           idx;
    logic [W-1:0] wr_seen [$];

    tv[0] = '{1'b1, 16'h00A0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[1] = '{1'b1, 16'h00A0, 1'b1, 1'b0, 16'h0000, 1'b1};
    tv[2] = '{1'b1, 16'h00A1, 1'b1, 1'b1, 16'h00A0, 1'b1};
    tv[3] = '{1'b1, 16'h00A2, 1'b1, 1'b1, 16'h00A1, 1'b1};
    tv[4] = '{1'b1, 16'h00A3, 1'b1, 1'b1, 16'h00A2, 1'b1};
    tv[5] = '{1'b1, 16'h00A4, 1'b0, 1'b1, 16'h00A3, 1'b0};
    tv[6] = '{1'b1, 16'h00A4, 1'b1, 1'b0, 16'h00A3, 1'b1};
    tv[7] = '{1'b1, 16'h00A5, 1'b1, 1'b1, 16'h00A4, 1'b1};
    tv[8] = '{1'b0, 16'h00A5, 1'b1, 1'b1, 16'h00A5, 1'b1};
    tv[9] = '{1'b0, 16'h00A5, 1'b0, 1'b0, 16'h00A5, 1'b0};

    #2;
    // Single requester, six words, burst split 4 + 2.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      req_valid = {3'b000, tv[r].v};
      req_data  = '0;
      req_data[W-1:0] = tv[r].d;
      #1;
      chk("t1_ready", req_ready, {3'b000, tv[r].rdy});
      chk("t1_wr_en", wr_en, tv[r].wr);
      chk("t1_data_in", data_in, tv[r].din);
      chk("t1_busy", busy, tv[r].bsy);
      chk("t1_owner", owner, 0);
      next();
    end

    // All requesters continuously valid: grants 0,1,2,3,0, four words each.
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'(16'h1100 * i);
    for (int b = 0; b < 5; b++) begin
      #1;
      chk("rr_arb_busy", busy, 0);
      next();
      for (int w = 0; w < BM; w++) begin
        #1;
        chk("rr_ready", req_ready, 64'd1 << (b % N));
        chk("rr_owner", owner, b % N);
        next();
      end
    end

    // FIFO full for 10 cycles in the middle of a burst from requester 2.
    do_reset();
    idx = 0;
    wr_seen.delete();
    for (int c = 0; c < 16; c++) begin
      full = (c >= 3 && c < 13);
      req_valid = (idx < 6) ? 4'b0100 : 4'b0000;
      req_data = '0;
      req_data[2*W +: W] = 16'(16'h00B0 + idx);
      #1;
      if (full) chk("stall_ready", req_ready, 0);
      if (c >= 4 && c <= 13) chk("stall_wr_en", wr_en, 0);
      if (c >= 1 && c <= 14) begin
        chk("stall_busy", busy, 1);
        chk("stall_owner", owner, 2);
      end
      if (c == 15) chk("stall_end_busy", busy, 0);
      if (wr_en) wr_seen.push_back(data_in);
      if (req_valid[2] && req_ready[2]) idx++;
      next();
    end
    full = 1'b0;
    chk("stall_accepted", idx, BM);
    chk("stall_written", wr_seen.size(), BM);
    for (int k = 0; k < wr_seen.size(); k++) chk("stall_word", wr_seen[k], 16'h00B0 + k);

    // Reset asserted mid-burst on requester 2.
    do_reset();
    req_valid = 4'b0100;
    req_data = '0;
    req_data[2*W +: W] = 16'h00C0;
    next();
    next();
    #1;
    chk("rstmid_pre_busy", busy, 1);
    chk("rstmid_pre_wr", wr_en, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_ready", req_ready, 0);
    chk("rstmid_wr_en", wr_en, 0);
    chk("rstmid_data_in", data_in, 0);
    chk("rstmid_owner", owner, 0);
    chk("rstmid_busy", busy, 0);
    next();
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("rstmid_idle", busy, 0);
    next();
    #1;
    chk("rstmid_first_owner", owner, 0);
    chk("rstmid_first_ready", req_ready, 4'b0001);
    next();

    // Overflow together with full: err latches, no ready issued.
    full = 1'b1;
    overflow = 1'b1;
    #1;
    chk("ovf_full_ready", req_ready, 0);
    chk("ovf_err_before", err, 0);
    next();
    full = 1'b0;
    overflow = 1'b0;
    #1;
    chk("ovf_err_set", err, 1);
    next(); next(); next();
    #1;
    chk("ovf_err_sticky", err, 1);
    rst = 1'b1;
    #1;
    chk("ovf_err_cleared", err, 0);
    next();

    // Fill an 8-deep FIFO with no reads: must stop at exactly 8.
    do_reset();
    run_rand(40, 0, 100);
    chk("fill_max", max_cnt, DEPTH);
    chk("fill_final", cnt + int'(wr_prev), DEPTH);

    // Random traffic with random draining.
    run_rand(3000, 55, 40);
    chk("rnd_no_overflow", max_cnt > DEPTH, 0);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], tx_cnt[i]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
